// File: rtl/shot_scheduler.sv
// Frame-paced round-robin shot arbiter: latches shoot requests, grants one eligible
// requester per i_cal_frame strobe and applies a per-requester cooldown in frames.
module shot_scheduler #(
    parameter int unsigned N_REQ           = 4,
    parameter int unsigned COOLDOWN_FRAMES = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_cal_frame,
    input  logic                       i_enable,
    input  logic [N_REQ-1:0]           i_shoot_req,
    output logic [N_REQ-1:0]           o_grant,
    output logic                       o_grant_valid,
    output logic [$clog2(N_REQ)-1:0]   o_grant_id,
    output logic [N_REQ-1:0]           o_pending,
    output logic [N_REQ-1:0]           o_cooldown_active
);

    localparam int unsigned IDW = $clog2(N_REQ);

    logic [N_REQ-1:0] r_pending;
    logic [N_REQ-1:0] r_grant;
    logic             r_grant_valid;
    logic [IDW-1:0]   r_grant_id;
    logic [IDW-1:0]   r_last;
    logic [7:0]       r_cnt [N_REQ];

    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_onehot;
    logic [N_REQ-1:0] w_clear;
    logic [IDW-1:0]   w_sel;
    logic             w_found;
    int unsigned      w_j;

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_elig[i]            = r_pending[i] & (r_cnt[i] == 8'd0) & i_enable;
            o_cooldown_active[i] = (r_cnt[i] != 8'd0);
        end
    end

    // Search starts one past the last granted index and wraps around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_j     = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_j = (32'(r_last) + k) % N_REQ;
            if (!w_found && w_elig[IDW'(w_j)]) begin
                w_found = 1'b1;
                w_sel   = IDW'(w_j);
            end
        end
    end

    assign w_onehot = w_found ? (N_REQ'(1) << w_sel) : '0;
    assign w_clear  = i_cal_frame ? w_onehot : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending     <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_last        <= IDW'(N_REQ - 1);
            for (int unsigned i = 0; i < N_REQ; i++) begin
                r_cnt[i] <= 8'd0;
            end
        end else begin
            // A pulse arriving with the strobe re-sets the bit the grant is clearing.
            if (i_enable) begin
                r_pending <= (r_pending & ~w_clear) | i_shoot_req;
            end else begin
                r_pending <= '0;
            end
            if (i_cal_frame) begin
                r_grant       <= w_onehot;
                r_grant_valid <= w_found;
                r_grant_id    <= w_found ? w_sel : '0;
                if (w_found) begin
                    r_last <= w_sel;
                end
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    if (w_onehot[i]) begin
                        r_cnt[i] <= 8'(COOLDOWN_FRAMES);
                    end else if (r_cnt[i] != 8'd0) begin
                        r_cnt[i] <= r_cnt[i] - 8'd1;
                    end
                end
            end
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_valid = r_grant_valid;
    assign o_grant_id    = r_grant_id;
    assign o_pending     = r_pending;

endmodule
